lcm_structural: RTL and testbench

//  Least common multiple of two unsigned WIDTH-bit operands by repeated addition: the additive

---
 rtl/lcm_structural.sv | 129 ++++++++++++
 tb/tb_lcm_structural.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/lcm_structural.sv
// rtl/lcm_structural.sv - LCM by repeated addition of two accumulators until they meet.
// Optional addition counter port iters is enabled by defining LCM_ITER_CNT_EN.
module lcm_structural #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               clear,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               ready,
    output logic               busy,
    output logic               done,
`ifdef LCM_ITER_CNT_EN
    output logic [2*WIDTH-1:0] lcm,
    output logic [WIDTH:0]     iters
`else
    output logic [2*WIDTH-1:0] lcm
`endif
);

    localparam int AW = 2 * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [AW-1:0]    acc_a;
    logic [AW-1:0]    acc_b;

    logic             load;
    logic             finish;
    logic             step;
    logic             any_zero;
    logic             acc_eq;
    logic             acc_lt;
    logic [AW-1:0]    add_lhs;
    logic [AW-1:0]    add_rhs;
    logic [AW-1:0]    add_sum;

    assign any_zero = (op_a == '0) || (op_b == '0);
    assign acc_eq   = (acc_a == acc_b);
    assign acc_lt   = (acc_a < acc_b);

    // Single shared adder: advance whichever accumulator is behind.
    assign add_lhs = acc_lt ? acc_a : acc_b;
    assign add_rhs = acc_lt ? {{WIDTH{1'b0}}, op_a} : {{WIDTH{1'b0}}, op_b};
    assign add_sum = add_lhs + add_rhs;

    assign busy = (state == S_RUN) || (state == S_DONE);
    assign done = (state == S_DONE);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        step       = 1'b0;
        case (state)
            S_IDLE: begin
                if (ready) begin
                    load       = 1'b1;
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (any_zero || acc_eq) begin
                    finish     = 1'b1;
                    state_next = S_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            acc_a <= '0;
            acc_b <= '0;
            lcm   <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                op_a  <= A;
                op_b  <= B;
                acc_a <= {{WIDTH{1'b0}}, A};
                acc_b <= {{WIDTH{1'b0}}, B};
            end
            if (finish) begin
                lcm <= any_zero ? '0 : acc_a;
            end
            if (step) begin
                if (acc_lt) begin
                    acc_a <= add_sum;
                end else begin
                    acc_b <= add_sum;
                end
            end
        end
    end

`ifdef LCM_ITER_CNT_EN
    always_ff @(posedge clk) begin
        if (!clear) begin
            iters <= '0;
        end else if (load) begin
            iters <= '0;
        end else if (step) begin
            iters <= iters + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lcm_structural.sv
// tb/tb_lcm_structural.sv - self-checking bench for lcm_structural against a gcd-based model.
module tb_lcm_structural;

    localparam int WIDTH = 4;

    logic               clk;
    logic               clear;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               ready;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] lcm;
`ifdef LCM_ITER_CNT_EN
    logic [WIDTH:0]     iters;
`endif

    int n_asserts = 0;
    int n_fails   = 0;
    int prev_lcm  = 0;

    lcm_structural #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .clear (clear),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .done  (done),
`ifdef LCM_ITER_CNT_EN
        .lcm   (lcm),
        .iters (iters)
`else
        .lcm   (lcm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int gcd(input int x, input int y);
        int a = x;
        int b = y;
        while (b != 0) begin
            int t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic check(input string tag, input int observed, input int expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and check result, latency and handshake.
    task automatic run_txn(input int a, input int b);
        int exp_l;
        int exp_n;
        int k;
        bit seen;
        if (a == 0 || b == 0) begin
            exp_l = 0;
            exp_n = 0;
        end else begin
            exp_l = (a * b) / gcd(a, b);
            exp_n = exp_l / a + exp_l / b - 2;
        end
        A     = a[WIDTH-1:0];
        B     = b[WIDTH-1:0];
        ready = 1'b1;
        tick();
        ready = 1'b0;
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        check($sformatf("busy_after_accept %0d,%0d", a, b), int'(busy), 1);
        check($sformatf("lcm_held_in_run %0d,%0d", a, b), int'(lcm), prev_lcm);
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 40) begin
            tick();
            k++;
            if (done) seen = 1'b1;
        end
        check($sformatf("done_seen %0d,%0d", a, b), int'(seen), 1);
        check($sformatf("latency %0d,%0d", a, b), k, exp_n + 1);
        check($sformatf("lcm %0d,%0d", a, b), int'(lcm), exp_l);
        check($sformatf("busy_in_done %0d,%0d", a, b), int'(busy), 1);
`ifdef LCM_ITER_CNT_EN
        check($sformatf("iters %0d,%0d", a, b), int'(iters), exp_n);
`endif
        tick();
        check($sformatf("idle_after_done %0d,%0d", a, b), int'({busy, done}), 0);
        check($sformatf("lcm_hold %0d,%0d", a, b), int'(lcm), exp_l);
        prev_lcm = exp_l;
    endtask

    initial begin
        clear = 1'b0;
        ready = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_lcm", int'(lcm), 0);
`ifdef LCM_ITER_CNT_EN
        check("reset_iters", int'(iters), 0);
`endif
        clear = 1'b1;
        tick();
        check("idle_no_ready", int'(busy), 0);

        run_txn(4, 6);
        run_txn(15, 15);
        run_txn(0, 7);
        run_txn(9, 0);
        run_txn(15, 14);

        // ready held high: accept, finish, return to IDLE, accept again.
        A     = 4'd1;
        B     = 4'd1;
        ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("cont_done cyc%0d", i), int'(done), (i % 3 == 2) ? 1 : 0);
            check($sformatf("cont_busy cyc%0d", i), int'(busy), (i % 3 == 0) ? 0 : 1);
        end
        ready = 1'b0;
        check("cont_lcm", int'(lcm), 1);
        prev_lcm = 1;
        tick();
        tick();
        check("cont_settled_idle", int'(busy), 0);

        // Abort mid-RUN.
        A     = 4'd13;
        B     = 4'd11;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("abort_run_busy %0d", i), int'({busy, done}), 2);
        end
        clear = 1'b0;
        tick();
        clear = 1'b1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_lcm", int'(lcm), 0);
`ifdef LCM_ITER_CNT_EN
        check("abort_iters", int'(iters), 0);
`endif
        prev_lcm = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("abort_no_done %0d", i), int'(done), 0);
        end
        run_txn(13, 11);

        for (int i = 0; i < 20; i++) begin
            run_txn(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
